// File: rtl/commit_trace_fifo_if.sv
// commit_trace_fifo_if: WB-side capture inputs, record drain handshake and status of the trace buffer
// slave: the trace buffer itself; master: the pipeline/consumer side driving inputs and rec_ready
interface commit_trace_fifo_if #(parameter int DEPTH = 16, parameter int CNT_W = 32);
  localparam int OW = $clog2(DEPTH) + 1;
  logic valid_in, exception_in;
  logic [31:0] pc_in, imm_in;
  logic [4:0] rs1n_in, rs2n_in, rdn_in;
  logic rec_valid, rec_ready, rec_last;
  logic [31:0] rec_pc, rec_imm;
  logic [4:0] rec_rs1n, rec_rs2n, rec_rdn;
  logic [OW-1:0] occupancy;
  logic overflow, halted, done;
  logic [CNT_W-1:0] dropped_cnt, retired_cnt, cycle_cnt;
  modport slave (
    input valid_in, exception_in, pc_in, imm_in, rs1n_in, rs2n_in, rdn_in, rec_ready,
    output rec_valid, rec_last, rec_pc, rec_imm, rec_rs1n, rec_rs2n, rec_rdn,
    output occupancy, overflow, halted, done, dropped_cnt, retired_cnt, cycle_cnt
  );
  modport master (
    output valid_in, exception_in, pc_in, imm_in, rs1n_in, rs2n_in, rdn_in, rec_ready,
    input rec_valid, rec_last, rec_pc, rec_imm, rec_rs1n, rec_rs2n, rec_rdn,
    input occupancy, overflow, halted, done, dropped_cnt, retired_cnt, cycle_cnt
  );
endinterface

// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: retirement trace FIFO with drop accounting, cycle/retire counters and exception halt
// Ports: clk, rst (async active-high); bus (slave) carries WB capture inputs, the rec_* valid/ready
// drain port, and the occupancy/overflow/counter/halted/done status outputs.
module commit_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  commit_trace_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int RW = 80;
  typedef enum logic [1:0] {RUN, HALTED, DONE} state_t;
  state_t r_state, w_next;
  logic [RW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [OW-1:0] r_occ;
  logic r_ovf;
  logic [CNT_W-1:0] r_drop, r_ret, r_cyc;
  logic w_cap, w_pop, w_push, w_drop, w_full;
  logic [RW-1:0] w_rec;
  assign w_full = r_occ == OW'(DEPTH);
  assign w_pop = bus.rec_valid & bus.rec_ready;
  assign w_cap = (r_state == RUN) & bus.valid_in;
  // A full FIFO still accepts when the head leaves in the same cycle
  assign w_push = w_cap & (~w_full | w_pop);
  assign w_drop = w_cap & ~w_push;
  assign w_rec = {bus.pc_in, bus.imm_in, bus.rs1n_in, bus.rs2n_in, bus.rdn_in, bus.exception_in};
  always_comb begin
    w_next = r_state;
    if (r_state == RUN)
      w_next = (w_cap & bus.exception_in) ? HALTED : RUN;
    else if (r_state == HALTED)
      w_next = (r_occ == '0 || (r_occ == OW'(1) && w_pop)) ? DONE : HALTED;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_wp <= '0;
      r_rp <= '0;
      r_occ <= '0;
      r_ovf <= 1'b0;
      r_drop <= '0;
      r_ret <= '0;
      r_cyc <= '0;
    end else begin
      r_state <= w_next;
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_occ <= r_occ + OW'(w_push) - OW'(w_pop);
      if (w_drop) r_ovf <= 1'b1;
      if (w_drop) r_drop <= r_drop + CNT_W'(r_drop != '1);
      if (w_cap) r_ret <= r_ret + CNT_W'(r_ret != '1);
      if (r_state == RUN) r_cyc <= r_cyc + CNT_W'(r_cyc != '1);
    end
  end
  // Storage needs no reset: nothing reaches rec_* unless occupancy covers it
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= w_rec;
  end
  assign bus.rec_valid = r_occ != '0;
  assign {bus.rec_pc, bus.rec_imm, bus.rec_rs1n, bus.rec_rs2n, bus.rec_rdn, bus.rec_last} =
    bus.rec_valid ? r_mem[r_rp] : '0;
  assign bus.occupancy = r_occ;
  assign bus.overflow = r_ovf;
  assign bus.dropped_cnt = r_drop;
  assign bus.retired_cnt = r_ret;
  assign bus.cycle_cnt = r_cyc;
  assign bus.halted = r_state != RUN;
  assign bus.done = r_state == DONE;
endmodule
